// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel matrix-memory front end.
//   ADDR_W  : row address width on the solver side
//   ROW_W   : row width delivered to the solver
//   SRAM_W  : SRAM data width; BEATS SRAM words make up one row
//   state_t : fetch sequencer states
//   beat_idx_t / row_addr_t : beat index and row address types
package gsim_pkg;

    localparam int ADDR_W = 10;
    localparam int ROW_W  = 256;
    localparam int SRAM_W = 64;
    localparam int BEATS  = ROW_W / SRAM_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [BEAT_W-1:0] beat_idx_t;
    typedef logic [ADDR_W-1:0] row_addr_t;

endpackage

// File: rtl/gsim_line_buf.sv
// One-entry row cache: assembled line register plus tag/valid.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write wr_data into the beat slot wr_idx of the line
//   inval       : clear valid (flush or start of a miss refill)
//   update      : line is complete; mark valid with update_tag
//   lookup_tag  : row address being requested
//   flush       : a flush in the lookup cycle forces a miss
//   hit         : lookup_tag matches a valid cached row
//   line        : assembled row, beat 0 in the least significant word
module gsim_line_buf
    import gsim_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  beat_idx_t         wr_idx,
    input  logic [SRAM_W-1:0] wr_data,
    input  logic              inval,
    input  logic              update,
    input  row_addr_t         update_tag,
    input  row_addr_t         lookup_tag,
    input  logic              flush,
    output logic              hit,
    output logic [ROW_W-1:0]  line
);

    logic      valid_reg;
    row_addr_t tag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [SRAM_W-1:0] word_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_idx == beat_idx_t'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign line[SRAM_W*gi +: SRAM_W] = word_reg;
        end
    endgenerate

    // Invalidation wins: a flush arriving in the final capture cycle must
    // keep the freshly assembled line from being marked valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
        end else if (inval) begin
            valid_reg <= 1'b0;
        end else if (update) begin
            valid_reg <= 1'b1;
            tag_reg   <= update_tag;
        end
    end

    assign hit = CACHE_EN && valid_reg && (tag_reg == lookup_tag) && !flush;

endmodule

// File: rtl/gsim_mem_fetch.sv
// Matrix-memory front end for the Gauss-Seidel solver.
// Serves one row read at a time: a cache hit answers next cycle, a miss
// reads BEATS words from a 1-cycle-latency SRAM and answers 6 cycles later.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_rreq, i_addr, o_rrdy: row request handshake (accept = i_rreq & o_rrdy)
//   o_dout, o_dout_vld    : assembled row and its one-cycle valid pulse
//   i_flush               : invalidate the cached row
//   o_sram_cen            : SRAM chip enable, active-low (read only)
//   o_sram_addr           : SRAM word address {row, beat}
//   i_sram_q              : SRAM read data, valid the cycle after issue
module gsim_mem_fetch
    import gsim_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_rreq,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic                     o_rrdy,
    output logic [ROW_W-1:0]         o_dout,
    output logic                     o_dout_vld,
    input  logic                     i_flush,
    output logic                     o_sram_cen,
    output logic [ADDR_W+BEAT_W-1:0] o_sram_addr,
    input  logic [SRAM_W-1:0]        i_sram_q
);

    state_t    state_reg, state_next;
    beat_idx_t beat_reg, beat_next;
    row_addr_t addr_reg;
    logic      rd_vld_reg;
    beat_idx_t rd_idx_reg;
    logic      flush_seen_reg;

    logic accept;
    logic hit;
    logic miss_start;
    logic update;

    assign accept     = i_rreq && o_rrdy;
    assign miss_start = accept && !hit;
    // A flush seen while the refill is in flight leaves the new line invalid.
    assign update     = (state_reg == WAIT) && !flush_seen_reg;

    gsim_line_buf #(
        .CACHE_EN (CACHE_EN)
    ) u_line_buf (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .wr_en      (rd_vld_reg),
        .wr_idx     (rd_idx_reg),
        .wr_data    (i_sram_q),
        .inval      (i_flush || miss_start),
        .update     (update),
        .update_tag (addr_reg),
        .lookup_tag (i_addr),
        .flush      (i_flush),
        .hit        (hit),
        .line       (o_dout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            beat_reg       <= '0;
            addr_reg       <= '0;
            rd_vld_reg     <= 1'b0;
            rd_idx_reg     <= '0;
            flush_seen_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            if (accept) begin
                addr_reg <= i_addr;
            end
            // SRAM data returns one cycle after issue; delay tag the beat.
            rd_vld_reg <= (state_reg == FETCH);
            rd_idx_reg <= beat_reg;
            if (miss_start) begin
                flush_seen_reg <= 1'b0;
            end else if (((state_reg == FETCH) || (state_reg == WAIT)) && i_flush) begin
                flush_seen_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        o_rrdy      = 1'b0;
        o_dout_vld  = 1'b0;
        o_sram_cen  = 1'b1;
        o_sram_addr = '0;

        case (state_reg)
            IDLE: begin
                o_rrdy = 1'b1;
                if (i_rreq) begin
                    state_next = hit ? RESP : FETCH;
                    beat_next  = '0;
                end
            end
            FETCH: begin
                o_sram_cen  = 1'b0;
                o_sram_addr = {addr_reg, beat_reg};
                beat_next   = beat_idx_t'(beat_reg + 1'b1);
                if (beat_reg == beat_idx_t'(BEATS - 1)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                o_rrdy     = 1'b1;
                o_dout_vld = 1'b1;
                if (i_rreq) begin
                    state_next = hit ? RESP : FETCH;
                    beat_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gsim_mem_fetch.sv
// Self-checking bench: instance 0 has the row cache enabled, instance 1 has
// it disabled. A shared read-only SRAM image feeds both.
module tb_gsim_mem_fetch;

    logic        clk;
    logic        rst_n;
    logic        rreq   [2];
    logic [9:0]  addr   [2];
    logic        flush  [2];
    logic        rrdy   [2];
    logic [255:0] dout  [2];
    logic        vld    [2];
    logic        cen    [2];
    logic [11:0] saddr  [2];
    logic [63:0] q      [2];

    logic [63:0] mem [0:4095];

    int errors = 0;
    int checks = 0;

    // Reference model: per instance, is some row cached and which one.
    bit         m_en    [2] = '{1'b1, 1'b0};
    bit         m_valid [2];
    logic [9:0] m_tag   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            gsim_mem_fetch #(
                .CACHE_EN (gi == 0)
            ) u_dut (
                .i_clk       (clk),
                .i_rst_n     (rst_n),
                .i_rreq      (rreq[gi]),
                .i_addr      (addr[gi]),
                .o_rrdy      (rrdy[gi]),
                .o_dout      (dout[gi]),
                .o_dout_vld  (vld[gi]),
                .i_flush     (flush[gi]),
                .o_sram_cen  (cen[gi]),
                .o_sram_addr (saddr[gi]),
                .i_sram_q    (q[gi])
            );
        end
    endgenerate

    // Single-port SRAM, 1-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!cen[k]) q[k] <= mem[saddr[k]];
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request on instance k. fl: flush in the accept cycle.
    // fl_mid: flush pulse in the second fetch cycle (only for misses).
    task automatic do_req(input int k, input logic [9:0] a, input bit fl, input bit fl_mid);
        int          cyc;
        int          n_iss;
        int          wt;
        bit          exp_hit;
        bit          got_vld;
        bit          mid;
        logic [255:0] exp_row;
        logic [1:0]  nb;
        logic [11:0] ea;

        exp_hit = m_en[k] && m_valid[k] && (m_tag[k] == a) && !fl;
        mid     = fl_mid && !exp_hit;
        for (int b = 0; b < 4; b++) begin
            ea = {a, 2'b00} + 12'(b);
            exp_row[64*b +: 64] = mem[ea];
        end

        wt = 0;
        while (!rrdy[k] && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        if (!rrdy[k]) check("rrdy_timeout", 256'(rrdy[k]), 256'(1));

        rreq[k]  = 1'b1;
        addr[k]  = a;
        flush[k] = fl;
        @(posedge clk);
        #1;
        rreq[k]  = 1'b0;
        flush[k] = 1'b0;
        if (fl || !exp_hit) m_valid[k] = 1'b0;

        cyc = 0;
        n_iss = 0;
        got_vld = 1'b0;
        while (!got_vld && cyc < 20) begin
            @(negedge clk);
            cyc++;
            flush[k] = mid && (cyc == 2);
            if (!cen[k]) begin
                nb = n_iss[1:0];
                check("sram_addr", 256'(saddr[k]), 256'({a, nb}));
                n_iss++;
            end
            if (vld[k]) got_vld = 1'b1;
        end
        flush[k] = 1'b0;

        check("latency", 256'(cyc), exp_hit ? 256'(1) : 256'(6));
        check("sram_reads", 256'(n_iss), exp_hit ? 256'(0) : 256'(4));
        check("row_data", dout[k], exp_row);
        $display("txn dut%0d addr=%0d flush=%0d mid_flush=%0d hit=%0d latency=%0d reads=%0d",
                 k, a, fl, mid, exp_hit, cyc, n_iss);

        if (!exp_hit && !mid) begin
            m_valid[k] = 1'b1;
            m_tag[k]   = a;
        end
    endtask

    task automatic idle_flush(input int k);
        flush[k] = 1'b1;
        @(negedge clk);
        flush[k] = 1'b0;
        m_valid[k] = 1'b0;
        $display("flush dut%0d", k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] ra;
        int         sel;

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rreq[k] = 1'b0;
            addr[k] = '0;
            flush[k] = 1'b0;
            m_valid[k] = 1'b0;
            m_tag[k] = '0;
        end
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[20 + i] = 64'(i);

        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_rrdy", 256'(rrdy[k]), 256'(1));
            check("rst_vld", 256'(vld[k]), 256'(0));
            check("rst_dout", dout[k], 256'(0));
            check("rst_cen", 256'(cen[k]), 256'(1));
            check("rst_saddr", 256'(saddr[k]), 256'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, then back-to-back hit.
        do_req(0, 10'd5, 1'b0, 1'b0);
        check("cold_row", dout[0], {64'd3, 64'd2, 64'd1, 64'd0});
        do_req(0, 10'd5, 1'b0, 1'b0);

        // Back-to-back misses on 5 then 6.
        idle_flush(0);
        do_req(0, 10'd5, 1'b0, 1'b0);
        do_req(0, 10'd6, 1'b0, 1'b0);

        // Flush coinciding with accept of the cached row.
        do_req(0, 10'd6, 1'b1, 1'b0);
        do_req(0, 10'd6, 1'b0, 1'b0);

        // Flush during a fetch keeps that row uncached.
        do_req(0, 10'd7, 1'b0, 1'b1);
        do_req(0, 10'd7, 1'b0, 1'b0);

        // Randomized traffic on the cached instance.
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            ra = (sel == 3) ? 10'($urandom_range(0, 1023)) : 10'(5 + sel);
            do_req(0, ra, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 9) == 0) idle_flush(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset asserted while beat 2 is being issued.
        idle_flush(0);
        rreq[0] = 1'b1;
        addr[0] = 10'd5;
        @(posedge clk);
        #1;
        rreq[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_saddr", 256'(saddr[0]), 256'({10'd5, 2'd2}));
        rst_n = 1'b0;
        #1;
        check("mid_rst_cen", 256'(cen[0]), 256'(1));
        check("mid_rst_rrdy", 256'(rrdy[0]), 256'(1));
        check("mid_rst_vld", 256'(vld[0]), 256'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            check("mid_rst_novld", 256'(vld[0]), 256'(0));
        end
        $display("reset mid-fetch dut0");
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        do_req(0, 10'd5, 1'b0, 1'b0);

        // Cache disabled: repeats still miss.
        do_req(1, 10'd7, 1'b0, 1'b0);
        do_req(1, 10'd7, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            do_req(1, 10'($urandom_range(5, 7)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
